instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_seq_pkg.sv | 17 +
 rtl/instr_sequencer_progmem.sv | 26 ++
 rtl/instr_sequencer.sv | 127 ++++++++++++
 tb/tb_instr_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Word layout: opcode [8:6], rs [5:4], rt [3:2], rd [1:0].
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int INSTR_W = 9;
  localparam int OP_W    = 3;
  localparam int REG_W   = 2;

  localparam logic [OP_W-1:0] HALT_OP = 3'b111;

endpackage

// File: rtl/instr_sequencer_progmem.sv
// Program buffer: one synchronous write port,
// one asynchronous read port.
module progMem #(
  parameter int DEPTH = 16,
  parameter int W     = 9,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Loads a small program and issues it one word
// per cycle (run) or one word per request (step).
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               LoadEn,
  input  logic [INSTR_W-1:0] LoadData,
  output logic               LoadReady,
  input  logic               ClearProg,
  input  logic               Start,
  input  logic               StepReq,
  input  logic               Stop,
  output logic [INSTR_W-1:0] Instruction,
  output logic               IssueValid,
  output logic [AW-1:0]      PC,
  output logic [AW-1:0]      Count,
  output logic               Busy,
  output logic               Done
);

  localparam int IW = $clog2(DEPTH);

  state_t             state;
  logic [INSTR_W-1:0] rdata;
  logic               room;
  logic               halt;
  logic               avail;
  logic               we;
  logic [AW-1:0]      count_inc;

  assign count_inc = Count + AW'(1);
  assign room      = Count < AW'(DEPTH);
  assign halt      = rdata[INSTR_W-1 -: OP_W] == HALT_OP;
  assign avail     = (PC < Count) && !halt;

  // Mirrors the load branch below: clear wins, reset overrides.
  assign we = RST_N && LoadEn && LoadReady
           && !ClearProg && (state != RUN);

  progMem #(
    .DEPTH(DEPTH),
    .W    (INSTR_W)
  ) u_mem (
    .clk  (CLK),
    .we   (we),
    .waddr(Count[IW-1:0]),
    .wdata(LoadData),
    .raddr(PC[IW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      PC          <= '0;
      Count       <= '0;
      Instruction <= '0;
      IssueValid  <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      LoadReady   <= 1'b1;
    end else begin
      IssueValid <= 1'b0;
      unique case (state)
        RUN: begin
          if (Stop) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            LoadReady <= room;
          end else if (avail) begin
            Instruction <= rdata;
            IssueValid  <= 1'b1;
            PC          <= PC + AW'(1);
          end else begin
            state     <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            LoadReady <= room;
          end
        end
        IDLE, DONE: begin
          if (ClearProg) begin
            state     <= IDLE;
            Done      <= 1'b0;
            Count     <= '0;
            PC        <= '0;
            LoadReady <= 1'b1;
          end else if (LoadEn && LoadReady) begin
            Count     <= count_inc;
            LoadReady <= count_inc < AW'(DEPTH);
          end else if (Start) begin
            PC <= '0;
            if (Count == '0) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state     <= RUN;
              Busy      <= 1'b1;
              Done      <= 1'b0;
              LoadReady <= 1'b0;
            end
          end else if (StepReq && state == IDLE) begin
            if (avail) begin
              Instruction <= rdata;
              IssueValid  <= 1'b1;
              PC          <= PC + AW'(1);
            end else begin
              state <= DONE;
              Done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector
// table for the main flow plus hand-written corners.
module tb_instr_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LoadEn;
  logic [8:0] LoadData;
  logic       LoadReady;
  logic       ClearProg;
  logic       Start;
  logic       StepReq;
  logic       Stop;
  logic [8:0] Instruction;
  logic       IssueValid;
  logic [4:0] PC;
  logic [4:0] Count;
  logic       Busy;
  logic       Done;

  int n_chk  = 0;
  int n_fail = 0;

  instr_sequencer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LoadEn     (LoadEn),
    .LoadData   (LoadData),
    .LoadReady  (LoadReady),
    .ClearProg  (ClearProg),
    .Start      (Start),
    .StepReq    (StepReq),
    .Stop       (Stop),
    .Instruction(Instruction),
    .IssueValid (IssueValid),
    .PC         (PC),
    .Count      (Count),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ld;
    logic [8:0] data;
    logic       clr;
    logic       st;
    logic       stp;
    logic       sp;
    logic       iv;
    logic [8:0] ins;
    int         pc;
    int         cnt;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  function automatic vec_t mk(
    logic ld, logic [8:0] data, logic clr,
    logic st, logic stp, logic sp,
    logic iv, logic [8:0] ins, int pc, int cnt,
    logic busy, logic done, logic rdy);
    vec_t v;
    v.ld = ld; v.data = data; v.clr = clr;
    v.st = st; v.stp = stp; v.sp = sp;
    v.iv = iv; v.ins = ins; v.pc = pc;
    v.cnt = cnt; v.busy = busy; v.done = done;
    v.rdy = rdy;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic idle_in();
    LoadEn = 0; LoadData = '0; ClearProg = 0;
    Start = 0; StepReq = 0; Stop = 0;
  endtask

  task automatic load(logic [8:0] d);
    LoadEn = 1; LoadData = d;
    tick();
    LoadEn = 0;
  endtask

  task automatic pulse_clear();
    ClearProg = 1; tick(); ClearProg = 0;
  endtask

  task automatic pulse_start();
    Start = 1; tick(); Start = 0;
  endtask

  task automatic pulse_step();
    StepReq = 1; tick(); StepReq = 0;
  endtask

  logic [8:0] w [7];
  vec_t       tbl [19];
  int         issues;
  logic       seen_bad;

  initial begin
    w[0] = 9'b100111110; w[1] = 9'b100100011;
    w[2] = 9'b000101101; w[3] = 9'b110011011;
    w[4] = 9'b010101101; w[5] = 9'b110110110;
    w[6] = 9'b001011011;

    for (int i = 0; i < 7; i++)
      tbl[i] = mk(1, w[i], 0, 0, 0, 0,
                  0, 9'h0, 0, i + 1, 0, 0, 1);
    tbl[7] = mk(0, 0, 0, 1, 0, 0,
                0, 9'h0, 0, 7, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      tbl[8 + i] = mk(0, 0, 0, 0, 0, 0,
                      1, w[i], i + 1, 7, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,
                 0, w[6], 7, 7, 0, 1, 1);
    tbl[16] = mk(0, 0, 1, 0, 0, 0,
                 0, w[6], 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 1, 0, 0,
                 0, w[6], 0, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 1, 0, 0, 0,
                 0, w[6], 0, 0, 0, 0, 1);

    RST_N = 0;
    idle_in();
    tick();
    tick();
    RST_N = 1;
    chk("rst iv", IssueValid, 0);
    chk("rst ins", Instruction, 0);
    chk("rst pc", PC, 0);
    chk("rst cnt", Count, 0);
    chk("rst busy", Busy, 0);
    chk("rst done", Done, 0);
    chk("rst rdy", LoadReady, 1);

    // Main flow: load, run, done, clear, empty start.
    for (int i = 0; i < 19; i++) begin
      LoadEn    = tbl[i].ld;
      LoadData  = tbl[i].data;
      ClearProg = tbl[i].clr;
      Start     = tbl[i].st;
      StepReq   = tbl[i].stp;
      Stop      = tbl[i].sp;
      tick();
      idle_in();
      chk($sformatf("v%0d iv", i), IssueValid, tbl[i].iv);
      chk($sformatf("v%0d ins", i), Instruction, tbl[i].ins);
      chk($sformatf("v%0d pc", i), PC, tbl[i].pc);
      chk($sformatf("v%0d cnt", i), Count, tbl[i].cnt);
      chk($sformatf("v%0d busy", i), Busy, tbl[i].busy);
      chk($sformatf("v%0d done", i), Done, tbl[i].done);
      chk($sformatf("v%0d rdy", i), LoadReady, tbl[i].rdy);
    end

    // HALT stops the run and is never issued.
    load(9'b100111110);
    load(9'b111000000);
    load(9'b010101101);
    pulse_start();
    issues = 0;
    seen_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (IssueValid) issues++;
      if (IssueValid && Instruction == 9'b010101101)
        seen_bad = 1;
    end
    chk("halt issues", issues, 1);
    chk("halt never", seen_bad, 0);
    chk("halt done", Done, 1);
    chk("halt pc", PC, 1);
    chk("halt ins", Instruction, 9'b100111110);

    // Stop after two issues, then single steps.
    pulse_clear();
    for (int i = 0; i < 7; i++) load(w[i]);
    pulse_start();
    tick();
    tick();
    chk("stop pre pc", PC, 2);
    Stop = 1; tick(); Stop = 0;
    chk("stop iv", IssueValid, 0);
    chk("stop busy", Busy, 0);
    chk("stop done", Done, 0);
    chk("stop pc", PC, 2);
    for (int i = 2; i < 5; i++) begin
      pulse_step();
      chk($sformatf("step%0d iv", i), IssueValid, 1);
      chk($sformatf("step%0d ins", i), Instruction, w[i]);
      chk($sformatf("step%0d pc", i), PC, i + 1);
      chk($sformatf("step%0d busy", i), Busy, 0);
      tick();
      chk($sformatf("step%0d iv0", i), IssueValid, 0);
    end
    chk("step done", Done, 0);

    // Reset in the middle of a run.
    pulse_clear();
    for (int i = 0; i < 7; i++) load(w[i]);
    pulse_start();
    tick();
    tick();
    tick();
    chk("mid pc", PC, 3);
    chk("mid busy", Busy, 1);
    RST_N = 0; tick(); RST_N = 1;
    chk("mrst iv", IssueValid, 0);
    chk("mrst pc", PC, 0);
    chk("mrst cnt", Count, 0);
    chk("mrst busy", Busy, 0);
    chk("mrst rdy", LoadReady, 1);
    tick();
    chk("mrst idle iv", IssueValid, 0);

    // Full buffer: 17th load ignored, contents intact.
    for (int i = 0; i < 16; i++)
      load({3'(i % 7), 6'(i)});
    chk("full rdy", LoadReady, 0);
    chk("full cnt", Count, 16);
    load(9'h1FF);
    chk("full17 cnt", Count, 16);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("full ins%0d", i), Instruction,
          {3'(i % 7), 6'(i)});
    end
    tick();
    chk("full done", Done, 1);
    chk("full pc", PC, 16);
    chk("full iv", IssueValid, 0);

    // Start beats StepReq; step onto HALT goes DONE.
    pulse_clear();
    load(w[0]);
    Start = 1; StepReq = 1; tick(); idle_in();
    chk("st+sp busy", Busy, 1);
    chk("st+sp iv", IssueValid, 0);
    Stop = 1; tick(); Stop = 0;
    pulse_clear();
    load(9'b111000000);
    pulse_step();
    chk("sphalt done", Done, 1);
    chk("sphalt iv", IssueValid, 0);
    chk("sphalt pc", PC, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
